// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the reset sequencer slice.
// Pure declarations: no logic, no latency.
// No flow control; consumed by the sequencer, its timer and its interface.
package venera_reset_pkg;

  // Sequencer states; the encoding is visible to debug tooling, keep it fixed
  typedef enum logic [1:0] {
    ASSERT = 2'd0,
    STAGE  = 2'd1,
    RUN    = 2'd2,
    FAULT  = 2'd3
  } state_e;

  // Why the most recent reset happened (3 is reserved)
  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_SW  = 2'd1;
  localparam logic [1:0] CAUSE_WDT = 2'd2;

  // Width of a domain index; a single domain still needs one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Bundles the request, ready and reset/status signals of the reset sequencer.
// Wires only, no latency.
// No backpressure: requests are pulses, ready is a level.
interface reset_sequencer_if
  import venera_reset_pkg::*;
#(
  parameter int N_DOMAINS = 4
);
  localparam int IDX_W = idx_width(N_DOMAINS);

  logic                 sw_reset_req;
  logic                 wdt_expired;
  logic [N_DOMAINS-1:0] ready_i;
  logic [N_DOMAINS-1:0] domain_reset_o;
  logic                 cpu_run;
  logic                 busy;
  logic                 fault;
  logic [1:0]           reset_cause;
  logic [IDX_W-1:0]     fault_domain;

  // Sequencer side: drives domain resets and status
  modport master (
    input  sw_reset_req, wdt_expired, ready_i,
    output domain_reset_o, cpu_run, busy, fault, reset_cause, fault_domain
  );

  // Environment side: issues requests and acknowledges
  modport slave (
    output sw_reset_req, wdt_expired, ready_i,
    input  domain_reset_o, cpu_run, busy, fault, reset_cause, fault_domain
  );

endinterface

// File: rtl/reset_sequencer_timer.sv
// Saturating up-counter with terminal-count flags for hold, stage and timeout.
// Flags are combinational from the registered count (0 cycles); count updates next edge.
// No backpressure; clear has priority over enable.
module rst_seq_timer #(
  parameter int CNT_W       = 16,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_DELAY = 4,
  parameter int TIMEOUT     = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic hold_done_o,
  output logic stage_min_o,
  output logic timeout_o
);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(STAGE_DELAY - 1 + TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up but never wrap
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign hold_done_o = (cnt_q == HOLD_LAST);
  assign stage_min_o = (cnt_q >= STAGE_LAST);
  assign timeout_o   = (cnt_q == TMO_LAST);

endmodule

// File: rtl/reset_sequencer.sv
// Holds all CPU reset domains, then releases them in index order gated on each ready.
// One edge from request/decision to registered outputs; releases spaced >= STAGE_DELAY.
// No backpressure; a late ready stretches the stage until TIMEOUT, then FAULT.
module reset_sequencer
  import venera_reset_pkg::*;
#(
  parameter int N_DOMAINS   = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_DELAY = 4,
  parameter int TIMEOUT     = 32,
  parameter int CNT_W       = 16
) (
  input logic              clk,
  input logic              reset_n,
  reset_sequencer_if.master bus
);
  localparam int IDX_W = idx_width(N_DOMAINS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DOMAINS - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d, nxt_idx;
  logic [N_DOMAINS-1:0] dr_q, dr_d;
  logic [1:0]           cause_q, cause_d;
  logic [IDX_W-1:0]     fdom_q, fdom_d;
  logic                 cpu_run_q, busy_q, fault_q;
  logic                 tmr_clr, tmr_en;
  logic                 hold_done, stage_min, timeout;
  logic                 req_any;

  rst_seq_timer #(
    .CNT_W(CNT_W), .HOLD_CYCLES(HOLD_CYCLES),
    .STAGE_DELAY(STAGE_DELAY), .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk(clk), .reset_n(reset_n), .clr_i(tmr_clr), .en_i(tmr_en),
    .hold_done_o(hold_done), .stage_min_o(stage_min), .timeout_o(timeout)
  );

  assign req_any = bus.sw_reset_req | bus.wdt_expired;
  assign nxt_idx = idx_q + 1'b1;

  // Next state, index, domain resets and cause; a request always beats a stage advance
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dr_d    = dr_q;
    cause_d = cause_q;
    fdom_d  = fdom_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    if ((state_q != FAULT) && req_any) begin
      state_d = ASSERT;
      idx_d   = '0;
      dr_d    = '1;
      tmr_clr = 1'b1;
      cause_d = bus.wdt_expired ? CAUSE_WDT : CAUSE_SW;
    end else begin
      case (state_q)
        ASSERT: begin
          if (hold_done) begin
            state_d = STAGE;
            idx_d   = '0;
            dr_d[0] = 1'b0;
            tmr_clr = 1'b1;
          end else begin
            tmr_en = 1'b1;
          end
        end
        STAGE: begin
          if (stage_min && bus.ready_i[idx_q]) begin
            tmr_clr = 1'b1;
            if (idx_q != LAST_IDX) begin
              idx_d         = nxt_idx;
              dr_d[nxt_idx] = 1'b0;
            end else begin
              state_d = RUN;
              dr_d    = '0;
            end
          end else if (timeout) begin
            state_d = FAULT;
            fdom_d  = idx_q;
            dr_d    = '1;
            tmr_clr = 1'b1;
          end else begin
            tmr_en = 1'b1;
          end
        end
        RUN: begin
          dr_d = '0;
        end
        default: begin
          // FAULT: watchdog is deliberately ignored, only software can restart
          dr_d = '1;
          if (bus.sw_reset_req) begin
            state_d = ASSERT;
            idx_d   = '0;
            tmr_clr = 1'b1;
            cause_d = CAUSE_SW;
          end
        end
      endcase
    end
  end

  // State and output registers; status flags follow the next state so they stay registered
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ASSERT;
      idx_q     <= '0;
      dr_q      <= '1;
      cause_q   <= CAUSE_POR;
      fdom_q    <= '0;
      cpu_run_q <= 1'b0;
      busy_q    <= 1'b1;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dr_q      <= dr_d;
      cause_q   <= cause_d;
      fdom_q    <= fdom_d;
      cpu_run_q <= (state_d == RUN);
      busy_q    <= (state_d == ASSERT) || (state_d == STAGE);
      fault_q   <= (state_d == FAULT);
    end
  end

  assign bus.domain_reset_o = dr_q;
  assign bus.cpu_run        = cpu_run_q;
  assign bus.busy           = busy_q;
  assign bus.fault          = fault_q;
  assign bus.reset_cause    = cause_q;
  assign bus.fault_domain   = fdom_q;

endmodule
